// File: rtl/four_dispatch_pkg.sv
// Shared constants and helpers for the four-way word dispatcher.
// Optional delivery statistics are enabled with FOUR_DISPATCH_STATS_EN.
package four_dispatch_pkg;

    localparam int WORD_BUS = 32;
    localparam int DEPTH    = 2;
    localparam int SEL_W    = 2;
    localparam int NUM_DST  = 4;

    typedef logic [SEL_W-1:0] dst_sel_t;

    function automatic logic [NUM_DST-1:0] sel_decode(input dst_sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/four_dispatch_fifo2.sv
// dispatch_fifo2: 2-entry synchronous FIFO with a registered head word that
// holds the last delivered value while empty.
module dispatch_fifo2
    import four_dispatch_pkg::*;
#(
    parameter int WIDTH   = WORD_BUS,
    parameter int ENTRIES = DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam logic [1:0] FULL_CNT = 2'(ENTRIES);

    logic [WIDTH-1:0] mem_q [0:1];
    logic [WIDTH-1:0] mem_d [0:1];
    logic [WIDTH-1:0] head_q, head_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Next-state: storage, pointers, occupancy and the head word
    always_comb begin
        do_push_s = push_i && (count_q != FULL_CNT);
        do_pop_s  = pop_i && (count_q != 2'd0);
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
        end else begin
            mem_d = mem_q;
        end
        wr_ptr_d = do_push_s ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop_s ? ~rd_ptr_q : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Empty buffer keeps presenting the last word it delivered
        head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = head_q;

endmodule

// File: rtl/four_dispatch.sv
// four_dispatch: routes one word stream to four buffered destinations.
// Define FOUR_DISPATCH_STATS_EN to add per-destination delivery counters.
module four_dispatch
    import four_dispatch_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_BUS,
    parameter int DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [1:0]                in_sel,
    input  logic [WORD_WIDTH-1:0]     in_data,
    output logic                      in_ready,
    output logic [3:0]                dst_valid,
    output logic [4*WORD_WIDTH-1:0]   dst_data,
    input  logic [3:0]                dst_ready
`ifdef FOUR_DISPATCH_STATS_EN
    ,
    output logic [4*8-1:0]            deliv_cnt
`endif
);

    logic [NUM_DST-1:0] sel_oh_s;
    logic [NUM_DST-1:0] full_s;
    logic [NUM_DST-1:0] empty_s;
    logic [NUM_DST-1:0] push_s;
    logic [NUM_DST-1:0] pop_s;

    // Readiness uses only registered full flags, never dst_ready
    assign sel_oh_s  = sel_decode(in_sel);
    assign in_ready  = ~full_s[in_sel];
    assign push_s    = {NUM_DST{in_valid && in_ready}} & sel_oh_s;
    assign dst_valid = ~empty_s;
    assign pop_s     = dst_valid & dst_ready;

    for (genvar g = 0; g < NUM_DST; g++) begin : g_buf
        dispatch_fifo2 #(
            .WIDTH   (WORD_WIDTH),
            .ENTRIES (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push_s[g]),
            .pop_i   (pop_s[g]),
            .data_i  (in_data),
            .full_o  (full_s[g]),
            .empty_o (empty_s[g]),
            .head_o  (dst_data[g*WORD_WIDTH +: WORD_WIDTH])
        );
    end

`ifdef FOUR_DISPATCH_STATS_EN
    logic [4*8-1:0] cnt_q, cnt_d;

    // Wrapping byte counters, one per destination
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_DST; i++) begin
            cnt_d[i*8 +: 8] = cnt_q[i*8 +: 8] + {7'd0, pop_s[i]};
        end
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign deliv_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_four_dispatch.sv
// Directed, table-driven bench for four_dispatch plus hand-written reset and
// statistics sequences (the latter only when FOUR_DISPATCH_STATS_EN is set).
module tb_four_dispatch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   in_sel;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [3:0]   dst_valid;
    logic [127:0] dst_data;
    logic [3:0]   dst_ready;
`ifdef FOUR_DISPATCH_STATS_EN
    logic [31:0]  deliv_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    four_dispatch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready)
`ifdef FOUR_DISPATCH_STATS_EN
        ,
        .deliv_cnt (deliv_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_dv;
        int          chk;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // Expectations are sampled before the edge of each step.
        vecs[0]  = '{1'b1, 2'd0, 32'd32,  4'b1111, 1'b1, 4'b0000, 0, 32'd0};
        vecs[1]  = '{1'b1, 2'd1, 32'd78,  4'b1111, 1'b1, 4'b0001, 0, 32'd32};
        vecs[2]  = '{1'b1, 2'd2, 32'd102, 4'b1111, 1'b1, 4'b0010, 1, 32'd78};
        vecs[3]  = '{1'b1, 2'd3, 32'd17,  4'b1111, 1'b1, 4'b0100, 2, 32'd102};
        vecs[4]  = '{1'b0, 2'd0, 32'd0,   4'b1111, 1'b1, 4'b1000, 3, 32'd17};
        vecs[5]  = '{1'b0, 2'd0, 32'd0,   4'b1111, 1'b1, 4'b0000, 3, 32'd17};
        vecs[6]  = '{1'b1, 2'd2, 32'd65,  4'b1011, 1'b1, 4'b0000, 2, 32'd102};
        vecs[7]  = '{1'b1, 2'd2, 32'd28,  4'b1011, 1'b1, 4'b0100, 2, 32'd65};
        vecs[8]  = '{1'b1, 2'd2, 32'd99,  4'b1011, 1'b0, 4'b0100, 2, 32'd65};
        vecs[9]  = '{1'b1, 2'd2, 32'd99,  4'b1111, 1'b0, 4'b0100, 2, 32'd65};
        vecs[10] = '{1'b1, 2'd2, 32'd99,  4'b1111, 1'b1, 4'b0100, 2, 32'd28};
        vecs[11] = '{1'b0, 2'd2, 32'd0,   4'b1111, 1'b1, 4'b0100, 2, 32'd99};
        vecs[12] = '{1'b0, 2'd2, 32'd0,   4'b1111, 1'b1, 4'b0000, 2, 32'd99};
        vecs[13] = '{1'b1, 2'd2, 32'd7,   4'b1011, 1'b1, 4'b0000, 2, 32'd99};
        vecs[14] = '{1'b1, 2'd2, 32'd8,   4'b1011, 1'b1, 4'b0100, 2, 32'd7};
        vecs[15] = '{1'b1, 2'd1, 32'd5,   4'b1011, 1'b1, 4'b0100, 2, 32'd7};
        vecs[16] = '{1'b0, 2'd2, 32'd0,   4'b1011, 1'b0, 4'b0110, 1, 32'd5};
        vecs[17] = '{1'b0, 2'd2, 32'd0,   4'b1011, 1'b0, 4'b0100, 2, 32'd7};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 32'd0;
        dst_ready = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_dst_valid", {124'd0, dst_valid}, 128'd0);
        check("reset_dst_data", dst_data, 128'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        end

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].v;
            in_sel    = vecs[i].sel;
            in_data   = vecs[i].data;
            dst_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_in_ready", i), {127'd0, in_ready}, {127'd0, vecs[i].exp_rdy});
            check($sformatf("vec%0d_dst_valid", i), {124'd0, dst_valid}, {124'd0, vecs[i].exp_dv});
            check($sformatf("vec%0d_dst_data", i), {96'd0, dst_data[vecs[i].chk*32 +: 32]},
                  {96'd0, vecs[i].exp_data});
        end

        // Two words parked on destination 3, then a one-cycle reset with a push offered.
        @(negedge clk);
        dst_ready = 4'b0000;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        in_data   = 32'd40;
        @(negedge clk);
        in_data   = 32'd41;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        check("pre_reset_dst_valid", {124'd0, dst_valid}, {124'd0, 4'b1100});
        check("pre_reset_dst_data3", {96'd0, dst_data[96 +: 32]}, 128'd40);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 32'd77;
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        dst_ready = 4'b1111;
        #1;
        check("mid_reset_dst_valid", {124'd0, dst_valid}, 128'd0);
        check("mid_reset_dst_data", dst_data, 128'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check("mid_reset_in_ready", {127'd0, in_ready}, 128'd1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("post_reset_no_stale", {124'd0, dst_valid}, 128'd0);
        end

`ifdef FOUR_DISPATCH_STATS_EN
        check("stats_after_reset", {96'd0, deliv_cnt}, 128'd0);
        for (int k = 0; k < 257; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_sel   = 2'd0;
            in_data  = 32'(k);
            #1;
            if (k == 100) check("stats_throughput_ready", {127'd0, in_ready}, 128'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stats_wrap", {96'd0, deliv_cnt}, 128'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
